bus_fabric: RTL and testbench
=============================

# bus_fabric

Parametrised single-master memory fabric between the picorv32 native memory port and up to `NUM_SLAVES` memory-mapped targets: ROM, RAM, GPIO and future peripherals.

It decodes each CPU request against per-slave base/mask pairs and forwards it to exactly one slave. The request is registered and then held until that slave's handshake completes. Unmapped accesses and slaves that never respond both terminate in a bus-error response, so the CPU never hangs.

## Interface
Parameters:
- `NUM_SLAVES`, 4: number of slave ports (1..16).
- `SLAVE_BASE`, 0: packed `NUM_SLAVES*32` bits; base address of slave i in bits [32i+31:32i].
- `SLAVE_MASK`, 0: packed `NUM_SLAVES*32` bits; slave i matches when `(addr & MASK_i) == BASE_i`.
- `TIMEOUT_CYCLES`, 64: maximum wait for slave ready (0 = timeout disabled).
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned on any bus error.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_mem_valid`  in  1  CPU request valid.
- `cpu_mem_addr`  in  32  byte address.
- `cpu_mem_wdata`  in  32  write data.
- `cpu_mem_wstrb`  in  4  byte strobes; 0 = read.
- `cpu_mem_rdata`  out  32  read data, valid while `cpu_mem_ready`.
- `cpu_mem_ready`  out  1  one-cycle completion pulse.
- `s_valid`  out  NUM_SLAVES  one-hot request to the selected slave.
- `s_addr`  out  32  latched address, shared by all slaves.
- `s_wdata`  out  32  latched write data, shared by all slaves.
- `s_wstrb`  out  4  latched strobes, shared by all slaves.
- `s_rdata`  in  NUM_SLAVES*32  packed slave read data.
- `s_ready`  in  NUM_SLAVES  slave completion.
- `err_pulse`  out  1  one-cycle pulse on each bus error.
- `err_flag`  out  1  sticky error indicator.
- `err_addr`  out  32  address of the first error since the last clear.
- `err_clr`  in  1  clears `err_flag` and `err_addr`.

## Operation
- FSM states are IDLE, ACCESS, RESP and ERR.
- **IDLE**
  - On `cpu_mem_valid`, latch addr, wdata and wstrb.
  - Decode: the lowest-index matching slave wins when regions overlap.
  - Match found: latch the index and go to ACCESS.
  - No match: go to ERR.
- **ACCESS**
  - `s_valid[idx]` = 1; all other `s_valid` bits = 0.
  - Timeout counter starts at 0 and increments each cycle `s_ready[idx]` is 0.
  - `s_ready[idx]` = 1: capture `s_rdata[idx]` into the response register and go to RESP.
  - Counter reaches `TIMEOUT_CYCLES-1` with no ready: go to ERR.
  - Ready and timeout in the same cycle: ready wins.
  - `s_ready` bits of unselected slaves are ignored.
- **RESP**
  - `cpu_mem_ready` = 1 for one cycle with the captured rdata, then go to IDLE.
- **ERR**
  - `cpu_mem_ready` = 1 for one cycle with `cpu_mem_rdata` = `ERR_RDATA`; `err_pulse` = 1; then go to IDLE.
  - Writes are dropped; no slave sees `s_valid` for an unmapped access.
- **Error capture**
  - `err_flag` sets on any ERR entry.
  - `err_addr` loads only when `err_flag` is 0, so it holds the first error.
  - `err_clr` has priority over a simultaneous new error: the flag ends cleared and `err_addr` is not loaded.
- **Upstream rules**
  - The CPU holds its request stable until `cpu_mem_ready` and drops `cpu_mem_valid` the following cycle (picorv32 behaviour).
  - IDLE accepts a new request no earlier than the cycle after RESP/ERR.
  - If `cpu_mem_valid` falls during ACCESS, the transaction still completes.
- `s_addr`, `s_wdata` and `s_wstrb` are registered and stable for the whole ACCESS state.

## Timing
- **Reset values**
  - State = IDLE.
  - `s_valid`, `cpu_mem_ready`, `err_pulse`, `err_flag` = 0.
  - `cpu_mem_rdata`, `err_addr`, `s_addr`, `s_wdata`, `s_wstrb` = 0.
- Reset asserted mid-transaction aborts immediately: `s_valid` drops asynchronously and no `cpu_mem_ready` is issued.
- **Latency**
  - Request seen at cycle 0; `s_valid` asserted in cycle 1.
  - Slave ready in cycle 1+k → `cpu_mem_ready` in cycle 2+k.
  - Minimum access latency is 2 cycles; unmapped access completes in 2 cycles.
- Timeout response arrives at cycle `TIMEOUT_CYCLES+1` after the request.
- `cpu_mem_rdata` is 0 outside RESP/ERR.
- All outputs are registered.

## Test plan
Bench setup: `NUM_SLAVES`=3 with these maps, `TIMEOUT_CYCLES`=8.
- Slave 0: base 0x0000_0000, mask 0xFFFF_0000.
- Slave 1: base 0x0001_0000, mask 0xFFFF_C000.
- Slave 2: base 0x0200_0000, mask 0xFFFF_FF00.

Scenarios:
- Read 0x0000_0004, slave 0 ready same cycle with rdata 0x1234_5678 → `s_valid`=001 for 1 cycle; `cpu_mem_ready` 2 cycles after request; rdata 0x1234_5678.
- Write 0x0001_0010, wdata 0xA5A5_0000, wstrb 4'b1100, slave 1 ready after 3 wait cycles → `s_wstrb`=1100 held throughout ACCESS; `cpu_mem_ready` at cycle 5.
- Read 0x0300_0000 (unmapped) → no `s_valid`; ready at cycle 2; rdata 0xDEAD_BEEF; `err_pulse`; `err_flag`=1; `err_addr`=0x0300_0000.
- Read 0x0200_0004, slave 2 never ready → ERR response at cycle 9; a second unmapped error leaves `err_addr`=0x0200_0004; `err_clr` → `err_flag`=0.
- Slave ready exactly on the timeout cycle → normal RESP with slave data; no error raised.
- `rst_n` pulsed low during ACCESS → `s_valid`=0 immediately; no `cpu_mem_ready`; after release a new read completes normally.

Source files
------------

// File: rtl/bus_fabric.sv
// Purpose : single-master fabric; decodes picorv32 native requests onto NUM_SLAVES targets.
// Latency : 2 cycles minimum (request -> cpu_mem_ready); slave wait k adds k; timeout answers at TIMEOUT_CYCLES+1.
// Backpres: one request in flight; slave stalls via s_ready, a stalled or unmapped access ends in a bus error.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cpu_mem_valid/addr/wdata/wstrb  CPU request (held stable until cpu_mem_ready)
//   cpu_mem_rdata/ready        registered response; ready is a one-cycle pulse
//   s_valid[NUM_SLAVES]        one-hot request to the decoded slave
//   s_addr/s_wdata/s_wstrb     latched request, shared by all slaves
//   s_rdata/s_ready            packed slave read data and completion
//   err_pulse/err_flag/err_addr/err_clr  bus-error reporting
module bus_fabric #(
  parameter int                        NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE     = '0,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK     = '0,
  parameter int                        TIMEOUT_CYCLES = 64,
  parameter logic [31:0]               ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_mem_valid,
  input  logic [31:0]                cpu_mem_addr,
  input  logic [31:0]                cpu_mem_wdata,
  input  logic [3:0]                 cpu_mem_wstrb,
  output logic [31:0]                cpu_mem_rdata,
  output logic                       cpu_mem_ready,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic                       err_pulse,
  output logic                       err_flag,
  output logic [31:0]                err_addr,
  input  logic                       err_clr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  logic [1:0]            state;
  logic [IDX_W-1:0]      idx;
  logic                  hit;
  logic [CNT_W-1:0]      cnt;

  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  access_ok;
  logic                  access_err;

  // Address decode; scanning from the top down lets the lowest matching index win.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((cpu_mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
    dec_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_onehot[i] = dec_hit && (dec_idx == IDX_W'(i));
    end
  end

  // Only the latched slave's ready/rdata are looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  // An unmapped request still spends one cycle in ACCESS (with no s_valid),
  // so mapped and unmapped accesses share the same 2-cycle minimum latency.
  // Ready is tested before the timeout, so ready on the last cycle wins.
  assign access_ok  = (state == ST_ACCESS) && hit && sel_ready;
  assign access_err = (state == ST_ACCESS) &&
                      (!hit || (TO_EN && !sel_ready && (cnt == CNT_LAST)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      hit           <= 1'b0;
      cnt           <= '0;
      s_valid       <= '0;
      s_addr        <= '0;
      s_wdata       <= '0;
      s_wstrb       <= '0;
      cpu_mem_ready <= 1'b0;
      cpu_mem_rdata <= '0;
      err_pulse     <= 1'b0;
    end else begin
      // Response outputs are pulses: they are only set on the edge entering RESP/ERR.
      cpu_mem_ready <= 1'b0;
      cpu_mem_rdata <= '0;
      err_pulse     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_mem_valid) begin
            s_addr  <= cpu_mem_addr;
            s_wdata <= cpu_mem_wdata;
            s_wstrb <= cpu_mem_wstrb;
            idx     <= dec_idx;
            hit     <= dec_hit;
            s_valid <= dec_onehot;
            cnt     <= '0;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (access_ok) begin
            s_valid       <= '0;
            cpu_mem_ready <= 1'b1;
            cpu_mem_rdata <= sel_rdata;
            state         <= ST_RESP;
          end else if (access_err) begin
            s_valid       <= '0;
            cpu_mem_ready <= 1'b1;
            cpu_mem_rdata <= ERR_RDATA;
            err_pulse     <= 1'b1;
            state         <= ST_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error capture; a clear in the same cycle as a new error wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (access_err) begin
      err_flag <= 1'b1;
      if (!err_flag) begin
        err_addr <= s_addr;
      end
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Purpose : randomized + directed scoreboard bench for bus_fabric (3 slaves, timeout 8).
// Latency : checks request-to-ready cycle counts against an address-map/wait-count model.
// Backpres: slave responder stalls a chosen number of cycles (or forever) per transaction.
module tb_bus_fabric;

  localparam int NS = 3;
  localparam int TO = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_mem_valid;
  logic [31:0]       cpu_mem_addr;
  logic [31:0]       cpu_mem_wdata;
  logic [3:0]        cpu_mem_wstrb;
  logic [31:0]       cpu_mem_rdata;
  logic              cpu_mem_ready;
  logic [NS-1:0]     s_valid;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic [NS*32-1:0]  s_rdata;
  logic [NS-1:0]     s_ready;
  logic              err_pulse;
  logic              err_flag;
  logic [31:0]       err_addr;
  logic              err_clr;

  bus_fabric #(
    .NUM_SLAVES    (NS),
    .SLAVE_BASE    ({32'h0200_0000, 32'h0001_0000, 32'h0000_0000}),
    .SLAVE_MASK    ({32'hFFFF_FF00, 32'hFFFF_C000, 32'hFFFF_0000}),
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (ERRD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_mem_valid(cpu_mem_valid),
    .cpu_mem_addr (cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wstrb(cpu_mem_wstrb),
    .cpu_mem_rdata(cpu_mem_rdata),
    .cpu_mem_ready(cpu_mem_ready),
    .s_valid      (s_valid),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_rdata      (s_rdata),
    .s_ready      (s_ready),
    .err_pulse    (err_pulse),
    .err_flag     (err_flag),
    .err_addr     (err_addr),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: address map and slave wait count -> outcome.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    bit          err;
    bit          clr;
    int          sel;
    int          lat;
    int          vcyc;
    int          req_cyc;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] m_base [NS] = '{32'h0000_0000, 32'h0001_0000, 32'h0200_0000};
  logic [31:0] m_mask [NS] = '{32'hFFFF_0000, 32'hFFFF_C000, 32'hFFFF_FF00};

  function automatic exp_t model(logic [31:0] addr, int wait_k, logic [31:0] srd, bit collide);
    exp_t e;
    e.addr = addr;
    e.clr  = collide;
    e.sel  = -1;
    e.req_cyc = 0;
    for (int i = 0; i < NS; i++)
      if (e.sel < 0 && ((addr & m_mask[i]) == m_base[i])) e.sel = i;
    if (e.sel < 0) begin
      e.err = 1'b1; e.rdata = ERRD; e.lat = 2;          e.vcyc = 0;
    end else if (wait_k >= TO) begin
      e.err = 1'b1; e.rdata = ERRD; e.lat = TO + 1;     e.vcyc = TO;
    end else begin
      e.err = 1'b0; e.rdata = srd;  e.lat = 2 + wait_k; e.vcyc = wait_k + 1;
    end
    return e;
  endfunction

  // Per-transaction context shared with the slave responder.
  int          exp_sel = -1;
  int          cur_wait = 0;
  logic [31:0] cur_rdata = '0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic [3:0]  cur_wstrb = '0;
  int          valid_cycles = 0;
  bit          m_flag = 1'b0;
  logic [31:0] m_addr = '0;

  // Slave responder: answers the expected slave after cur_wait cycles,
  // toggles unselected ready bits randomly, and checks the forwarded request.
  int          wcnt;
  logic [NS-1:0] ev;
  logic [NS-1:0] noise;
  initial begin
    wcnt = 0;
    s_ready = '0;
    s_rdata = '0;
    forever begin
      @(negedge clk);
      noise   = NS'($urandom);
      s_rdata = {$urandom, $urandom, $urandom};
      ev      = (exp_sel >= 0) ? NS'(1 << exp_sel) : '0;
      if (rst_n && s_valid != '0) begin
        check("s_valid_onehot", 32'(s_valid), 32'(ev));
        check("s_addr", s_addr, cur_addr);
        check("s_wdata", s_wdata, cur_wdata);
        check("s_wstrb", 32'(s_wstrb), 32'(cur_wstrb));
        valid_cycles++;
        if (exp_sel >= 0 && wcnt == cur_wait) begin
          s_ready = (noise & ~ev) | ev;
          s_rdata[exp_sel*32 +: 32] = cur_rdata;
        end else begin
          s_ready = noise & ~ev;
        end
        wcnt++;
      end else begin
        wcnt = 0;
        s_ready = noise;
      end
    end
  end

  // Monitor: pops an expectation on every cpu_mem_ready.
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cpu_mem_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ready: got ready with empty scoreboard (t=%0t)", $time);
          end else begin
            me = exp_q.pop_front();
            check("rdata", cpu_mem_rdata, me.rdata);
            check("latency", 32'(cyc - me.req_cyc), 32'(me.lat));
            check("err_pulse", 32'(err_pulse), 32'(me.err));
            check("s_valid_cycles", 32'(valid_cycles), 32'(me.vcyc));
            if (me.clr) begin
              m_flag = 1'b0;
              m_addr = '0;
            end else if (me.err) begin
              if (!m_flag) m_addr = me.addr;
              m_flag = 1'b1;
            end
            check("err_flag", 32'(err_flag), 32'(m_flag));
            check("err_addr", err_addr, m_addr);
          end
        end else begin
          check("idle_rdata", cpu_mem_rdata, 32'h0);
          check("idle_err_pulse", 32'(err_pulse), 32'h0);
        end
      end
    end
  end

  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input int wait_k, input logic [31:0] srd, input bit collide, input bit early_drop);
    exp_t e;
    int   n;
    @(negedge clk);
    e = model(addr, wait_k, srd, collide);
    e.req_cyc = cyc;
    exp_q.push_back(e);
    exp_sel = e.sel; cur_wait = wait_k; cur_rdata = srd;
    cur_addr = addr; cur_wdata = wdata; cur_wstrb = wstrb;
    valid_cycles = 0;
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = addr;
    cpu_mem_wdata = wdata;
    cpu_mem_wstrb = wstrb;
    for (n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (collide) err_clr = (n == 1);
      if (early_drop && n == 1) cpu_mem_valid = 1'b0;
      if (cpu_mem_ready) break;
    end
    if (n > 100) begin
      tests++;
      fails++;
      $display("FAIL txn_timeout: addr %h got no cpu_mem_ready, required one within 100 cycles", addr);
    end
    cpu_mem_valid = 1'b0;
    err_clr       = 1'b0;
    cpu_mem_addr  = $urandom;
    cpu_mem_wdata = $urandom;
    cpu_mem_wstrb = 4'($urandom);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_flag = 1'b0;
    m_addr = '0;
    check("clr_err_flag", 32'(err_flag), 32'h0);
    check("clr_err_addr", err_addr, 32'h0);
  endtask

  logic [31:0] ra;
  int          rw;
  int          rsel;

  initial begin
    rst_n = 1'b0;
    cpu_mem_valid = 1'b0;
    cpu_mem_addr  = '0;
    cpu_mem_wdata = '0;
    cpu_mem_wstrb = '0;
    err_clr = 1'b0;
    #12;
    check("rst_s_valid", 32'(s_valid), 32'h0);
    check("rst_cpu_ready", 32'(cpu_mem_ready), 32'h0);
    check("rst_cpu_rdata", cpu_mem_rdata, 32'h0);
    check("rst_err_pulse", 32'(err_pulse), 32'h0);
    check("rst_err_flag", 32'(err_flag), 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_s_wdata", s_wdata, 32'h0);
    check("rst_s_wstrb", 32'(s_wstrb), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios.
    txn(32'h0000_0004, 32'h0, 4'b0000, 0, 32'h1234_5678, 1'b0, 1'b0);
    txn(32'h0001_0010, 32'hA5A5_0000, 4'b1100, 3, 32'h0BAD_0001, 1'b0, 1'b0);
    txn(32'h0300_0000, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 1'b0);
    pulse_clr();
    txn(32'h0200_0004, 32'h0, 4'b0000, 1000, 32'h0, 1'b0, 1'b0);
    txn(32'h0300_0100, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 1'b0);
    pulse_clr();
    txn(32'h0200_0010, 32'h0, 4'b0000, TO - 1, 32'hCAFE_F00D, 1'b0, 1'b0);
    txn(32'h0300_0200, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 1'b0);
    txn(32'h0500_0000, 32'h0, 4'b0000, 0, 32'h0, 1'b1, 1'b0);
    txn(32'h0001_3FFC, 32'h1111_2222, 4'b1111, 2, 32'h3333_4444, 1'b0, 1'b1);

    // Reset asserted in the middle of an access to slave 0.
    @(negedge clk);
    exp_sel = 0; cur_wait = 1000; cur_addr = 32'h0000_0100; cur_wdata = '0; cur_wstrb = '0;
    cpu_mem_valid = 1'b1; cpu_mem_addr = 32'h0000_0100; cpu_mem_wdata = '0; cpu_mem_wstrb = '0;
    repeat (3) @(negedge clk);
    check("rst_mid_pre_s_valid", 32'(s_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_s_valid", 32'(s_valid), 32'h0);
    check("rst_mid_cpu_ready", 32'(cpu_mem_ready), 32'h0);
    check("rst_mid_s_addr", s_addr, 32'h0);
    cpu_mem_valid = 1'b0;
    m_flag = 1'b0;
    m_addr = '0;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_cpu_ready", 32'(cpu_mem_ready), 32'h0);
    end
    rst_n = 1'b1;
    txn(32'h0000_0008, 32'h0, 4'b0000, 1, 32'h7777_8888, 1'b0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      rsel = $urandom_range(0, 4);
      case (rsel)
        0:       ra = {16'h0000, 16'($urandom)};
        1:       ra = 32'h0001_0000 | ($urandom & 32'h0000_3FFF);
        2:       ra = 32'h0200_0000 | ($urandom & 32'h0000_00FF);
        3:       ra = $urandom;
        default: ra = 32'h0300_0000 | ($urandom & 32'h0000_FFFF);
      endcase
      rw = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 9));
      txn(ra, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, rw, $urandom,
          1'b0, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) pulse_clr();
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
